// File: rtl/fp32_div.sv
// Iterative IEEE-754 single-precision divider (result = a / b).
// Restoring radix-2 significand division producing one quotient bit per clock,
// followed by a single normalise/round cycle. Subnormals are flushed to zero.

package fp32_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  localparam float32_t ZERO32  = 32'h0000_0000;
  localparam float32_t P_INF32 = 32'h7F80_0000;
  localparam float32_t NAN32   = 32'h7FC0_0000;
endpackage

module fp32_div
  import fp32_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  float32_t a,
  input  float32_t b,
  output logic     out_valid,
  input  logic     out_ready,
  output float32_t result,
  output logic [4:0] flags   // {invalid, div_by_zero, overflow, underflow, inexact}
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      state;
  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic [23:0] mb_r;
  logic [24:0] rem;
  logic [25:0] q;
  logic [4:0]  cnt;

  // Operand classification and special-case result, decoded straight from the inputs
  logic     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, is_special;
  float32_t spec_result;
  logic [4:0] spec_flags;

  // Special-case detection in priority order; subnormal operands count as zero
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    spec_result = ZERO32;
    spec_flags  = 5'b0;
    a_zero = (a.exp == 8'h00);
    b_zero = (b.exp == 8'h00);
    a_inf  = (a.exp == 8'hFF) && (a.mant == 23'd0);
    b_inf  = (b.exp == 8'hFF) && (b.mant == 23'd0);
    a_nan  = (a.exp == 8'hFF) && (a.mant != 23'd0);
    b_nan  = (b.exp == 8'hFF) && (b.mant != 23'd0);
    is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    if (a_nan || b_nan) begin
      spec_result = NAN32;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = NAN32;
      spec_flags  = 5'b10000;
    end else if (a_inf) begin
      spec_result = {a.sign ^ b.sign, P_INF32[30:0]};
    end else if (b_zero) begin
      spec_result = {a.sign ^ b.sign, P_INF32[30:0]};
      spec_flags  = 5'b01000;
    end else begin
      // x/inf and 0/x both give a signed zero
      spec_result = {a.sign ^ b.sign, ZERO32[30:0]};
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;
  logic [25:0] q_next;

  always_comb begin
    rem_ge   = (rem >= {1'b0, mb_r});
    rem_sub  = rem_ge ? (rem - {1'b0, mb_r}) : rem;
    rem_next = {rem_sub[23:0], 1'b0};
    q_next   = {q[24:0], rem_ge};
  end

  // Normalise, round to nearest-even and range-check the finished quotient
  logic signed [9:0] e0, e1, e2;
  logic [22:0] frac, frac_r;
  logic        guard, sticky, round_up, carry, inexact;
  float32_t    norm_result;
  logic [4:0]  norm_flags;

  always_comb begin
    e0 = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd127;
    if (q[25]) begin
      frac   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (rem != 25'd0);
      e1     = e0;
    end else begin
      // Quotient below 1.0: take one more bit from below
      frac   = q[23:1];
      guard  = q[0];
      sticky = (rem != 25'd0);
      e1     = e0 - 10'sd1;
    end
    round_up        = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {23'd0, round_up};
    // A carry out of the fraction means 1.111..1 rounded up to 2.0
    e2      = carry ? (e1 + 10'sd1) : e1;
    inexact = guard | sticky;
    if (e2 >= 10'sd255) begin
      norm_result = {sign_r, P_INF32[30:0]};
      norm_flags  = 5'b00101;
    end else if (e2 <= 10'sd0) begin
      norm_result = {sign_r, ZERO32[30:0]};
      norm_flags  = 5'b00011;
    end else begin
      norm_result = {sign_r, e2[7:0], frac_r};
      norm_flags  = {4'b0000, inexact};
    end
  end

  // Control FSM with registered handshake outputs and the iterative datapath
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: only control and visible outputs are reset; datapath registers are always loaded before use.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= ZERO32;
      flags     <= 5'b0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= a.sign ^ b.sign;
            ea_r     <= a.exp;
            eb_r     <= b.exp;
            mb_r     <= {1'b1, b.mant};
            rem      <= {2'b01, a.mant};
            q        <= 26'd0;
            cnt      <= 5'd0;
            in_ready <= 1'b0;
            if (is_special) begin
              result    <= spec_result;
              flags     <= spec_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= NORM;
        end
        NORM: begin
          result    <= norm_result;
          flags     <= norm_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp32_div.md
Name: fp32_div

Overview:
- Iterative IEEE-754 single-precision divider (result = a / b), the inverse operation to fp32_mul in the FP32 arithmetic set.
- Uses the shared Float32 type and the ZERO32 / P_INF32 / NAN32 constants.
- Restoring radix-2 significand division, one quotient bit per clock, with valid/ready handshakes on both sides.
- Single clock; intended to sit next to fp32_mul behind the same operand-issue logic.

Parameters:
- None. The iteration count is fixed at 26 quotient bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  divider can accept operands.
- a  in  32 (Float32)  dividend.
- b  in  32 (Float32)  divisor.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  32 (Float32)  quotient.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE, in_ready=1, out_valid=0, result=ZERO32, flags=0.
  - Any in-flight operation is discarded; no output is produced for it.
- States: IDLE, CALC, NORM, DONE.
- IDLE:
  - in_ready=1.
  - An edge with in_valid & in_ready latches a and b.
  - Special case: go to DONE; out_valid is high the next cycle.
  - Otherwise: go to CALC with counter=0.
- Special cases, checked in this order:
  - Any NaN operand -> NAN32 (7FC00000), invalid=0.
  - 0/0 or inf/inf -> NAN32, invalid=1.
  - inf/x -> signed inf.
  - x/0 (x finite, nonzero) -> signed inf, div_by_zero=1.
  - x/inf -> signed zero.
  - 0/x -> signed zero.
- Subnormal handling:
  - Subnormal inputs (exp=0, mant≠0) are treated as signed zero.
  - Subnormal results are flushed to signed zero.
- Sign: sign = a.sign ^ b.sign for every result, including zero and inf. NaN output is always positive.
- CALC:
  - Significands ma = {1, a.mant} and mb = {1, b.mant} (24 bits).
  - Remainder starts at ma.
  - Each cycle: if rem ≥ mb, then q bit=1 and rem -= mb; else q bit=0. Then rem <<= 1.
  - Exactly 26 cycles (counter 0..25), then go to NORM.
- NORM (1 cycle):
  - Exponent e = ea - eb + 127, computed at ≥10-bit signed width.
  - If q[25]=0 (quotient < 1): shift q left by 1 and decrement e.
  - Round to nearest, ties to even. Use guard = next bit below the 24-bit significand; sticky = OR of the remaining q bits and (rem≠0).
  - inexact = guard | sticky.
  - A rounding carry-out sets the significand to 1.0 and increments e.
  - If e ≥ 255: result = signed inf, overflow=1, inexact=1.
  - If e ≤ 0: result = signed zero, underflow=1, inexact=1.
  - Then go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable.
  - in_ready=0 in every state except IDLE.
  - An edge with out_ready=1 goes to IDLE. out_valid falls the following cycle.
  - There is no bypass: a new operand cannot be accepted in the same cycle as the result handoff.
- Latency, counted from the acceptance edge to the first cycle with out_valid=1:
  - Special case: 1 cycle.
  - Normal operand: 28 cycles (26 CALC + 1 NORM + 1 entering DONE).
- rst asserted together with in_valid: reset wins and the operands are not latched.
- rst asserted during CALC or DONE: returns to IDLE at that edge.
- Throughput: one division per 29 cycles minimum.

Test Plan:
- 40C00000 / 40000000 (6.0/2.0) -> result 40400000, flags 0, out_valid exactly 28 cycles after acceptance.
- 3F800000 / 40400000 (1.0/3.0) -> 3EAAAAAB, inexact=1. C0C00000 / 40000000 -> C0400000 (sign check).
- Specials, each completing in 1 cycle:
  - 3F800000 / ZERO32 -> 7F800000, div_by_zero=1.
  - ZERO32 / ZERO32 -> 7FC00000, invalid=1.
  - P_INF32 / P_INF32 -> 7FC00000, invalid=1.
  - NAN32 / 3F800000 -> 7FC00000.
  - 3F800000 / P_INF32 -> 00000000.
- Range:
  - 7F7FFFFF / 3F000000 -> 7F800000, overflow=1.
  - 00800000 / 40000000 -> 00000000, underflow=1.
  - 00400000 (subnormal) / 3F800000 -> 00000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Result and flags must stay stable and in_ready=0; in_valid pulses in that window are ignored. Release -> out_valid drops the next cycle and in_ready=1.
- Reset mid-CALC: assert rst at cycle 10 of 40C00000/40000000 -> out_valid never rises, result=00000000, in_ready=1. A following 3F800000/3F800000 -> 3F800000.
